// File: rtl/ntt_pkg.sv
// Shared constants, types and address helper for the NTT butterfly scheduler.
// Optional NTT_SCHED_PINGPONG_EN adds a bank bit (bit 8) to every coefficient address.
package ntt_pkg;
  localparam int N            = 256;
  localparam int LOG_N        = 8;
  localparam int NUM_LAYERS   = 7;
  localparam int BF_PER_LAYER = 128;

`ifdef NTT_SCHED_PINGPONG_EN
  localparam int ADDR_W = 9;
`else
  localparam int ADDR_W = 8;
`endif

  localparam logic [1:0] BF_MODE_NTT  = 2'b00;
  localparam logic [1:0] BF_MODE_INTT = 2'b01;
  localparam logic [1:0] BF_MODE_BYP  = 2'b10;
  localparam logic [1:0] BF_MODE_IDLE = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_FIN} sched_state_e;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [6:0] tw;
  } bf_addr_t;

  typedef struct packed {
    logic       vld;
`ifdef NTT_SCHED_PINGPONG_EN
    logic       bank;
`endif
    logic [7:0] a;
    logic [7:0] b;
  } wb_t;

  // Cooley-Tukey (forward) shrinks the butterfly span per layer, Gentleman-Sande (inverse) grows it.
  function automatic bf_addr_t bf_addr(input logic inv, input logic [2:0] l, input logic [6:0] c);
    bf_addr_t r;
    int s, len, g, o, a;
    s   = inv ? int'(l) + 1 : 7 - int'(l);
    len = 1 << s;
    g   = int'(c) >> s;
    o   = int'(c) & (len - 1);
    a   = (g << (s + 1)) | o;
    r.a  = 8'(a);
    r.b  = 8'(a + len);
    r.tw = inv ? 7'((128 >> l) - 1 - g) : 7'((1 << l) + g);
    return r;
  endfunction
endpackage

// File: rtl/ntt_bf_sched_if.sv
// Scheduler bus: start/inv from the polynomial controller, read/write/twiddle strobes out.
interface ntt_bf_sched_if;
  import ntt_pkg::*;
  logic              i_start;
  logic              i_inv;
  logic              o_busy;
  logic              o_done;
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr_a;
  logic [ADDR_W-1:0] o_rd_addr_b;
  logic [6:0]        o_tw_addr;
  logic [1:0]        o_bf_mode;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr_a;
  logic [ADDR_W-1:0] o_wr_addr_b;

  modport slave (
    input  i_start, i_inv,
    output o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr, o_bf_mode,
           o_wr_en, o_wr_addr_a, o_wr_addr_b
  );
  modport master (
    output i_start, i_inv,
    input  o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr, o_bf_mode,
           o_wr_en, o_wr_addr_a, o_wr_addr_b
  );
endinterface

// File: rtl/ntt_wb_delay.sv
// Write-back delay line: read-side {valid, addresses} shifted by the memory+butterfly latency.
// Sized for the longer mode; the tap follows the latched direction.
module ntt_wb_delay
  import ntt_pkg::*;
#(
  parameter int D_NTT  = 6,
  parameter int D_INTT = 7
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inv,
  input  wb_t  i_d,
  output wb_t  o_q
);
  localparam int DEPTH = (D_NTT > D_INTT) ? D_NTT : D_INTT;

  wb_t r_pipe [1:DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 1; k <= DEPTH; k++) r_pipe[k] <= '0;
    end else begin
      r_pipe[1] <= i_d;
      for (int k = 2; k <= DEPTH; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  assign o_q = i_inv ? r_pipe[D_INTT] : r_pipe[D_NTT];
endmodule

// File: rtl/ntt_bf_sched.sv
// Radix-2 NTT/INTT butterfly sequencer for one 256-coefficient polynomial (7 layers x 128 butterflies).
// NTT_SCHED_PINGPONG_EN: reads from bank l[0], writes to bank ~l[0]; result ends in bank 1.
module ntt_bf_sched
  import ntt_pkg::*;
#(
  parameter int MEM_RD_LAT  = 1,
  parameter int BF_LAT_NTT  = 5,
  parameter int BF_LAT_INTT = 6
) (
  input  logic           i_clk,
  input  logic           i_rst,
  ntt_bf_sched_if.slave  bus
);
  localparam int D_NTT  = MEM_RD_LAT + BF_LAT_NTT;
  localparam int D_INTT = MEM_RD_LAT + BF_LAT_INTT;
  localparam logic [7:0] DL_NTT  = 8'(D_NTT - 1);
  localparam logic [7:0] DL_INTT = 8'(D_INTT - 1);

  sched_state_e r_state;
  logic         r_inv;
  logic [2:0]   r_layer;
  logic [6:0]   r_cnt;
  logic [7:0]   r_dcnt;
  logic         r_busy, r_done, r_rd_en;
  logic [7:0]   r_rd_a, r_rd_b;
  logic [6:0]   r_tw;
  logic [1:0]   r_mode;

  bf_addr_t     w_first;
  bf_addr_t     w_next;
  bf_addr_t     w_nlayer;
  logic [7:0]   w_dlast;
  wb_t          w_wb_in, w_wb_out;

  assign w_first  = bf_addr(bus.i_inv, 3'd0, 7'd0);
  assign w_next   = bf_addr(r_inv, r_layer, r_cnt + 7'd1);
  assign w_nlayer = bf_addr(r_inv, r_layer + 3'd1, 7'd0);
  assign w_dlast  = r_inv ? DL_INTT : DL_NTT;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_inv   <= 1'b0;
      r_layer <= '0;
      r_cnt   <= '0;
      r_dcnt  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_rd_a  <= '0;
      r_rd_b  <= '0;
      r_tw    <= '0;
      r_mode  <= BF_MODE_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.i_start) begin
          r_state <= ST_ISSUE;
          r_inv   <= bus.i_inv;
          r_layer <= '0;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
          r_rd_en <= 1'b1;
          r_rd_a  <= w_first.a;
          r_rd_b  <= w_first.b;
          r_tw    <= w_first.tw;
          r_mode  <= bus.i_inv ? BF_MODE_INTT : BF_MODE_NTT;
        end
        ST_ISSUE: begin
          if (r_cnt == 7'd127) begin
            r_state <= ST_DRAIN;
            r_rd_en <= 1'b0;
            r_dcnt  <= '0;
          end else begin
            r_cnt   <= r_cnt + 7'd1;
            r_rd_a  <= w_next.a;
            r_rd_b  <= w_next.b;
            r_tw    <= w_next.tw;
          end
        end
        // Drain until the layer's last write lands so the next layer reads fresh data.
        ST_DRAIN: begin
          r_dcnt <= r_dcnt + 8'd1;
          if (r_dcnt == w_dlast) begin
            if (r_layer == 3'(NUM_LAYERS - 1)) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_ISSUE;
              r_layer <= r_layer + 3'd1;
              r_cnt   <= '0;
              r_rd_en <= 1'b1;
              r_rd_a  <= w_nlayer.a;
              r_rd_b  <= w_nlayer.b;
              r_tw    <= w_nlayer.tw;
            end
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_mode  <= BF_MODE_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_wb_in.vld = r_rd_en;
  assign w_wb_in.a   = r_rd_a;
  assign w_wb_in.b   = r_rd_b;
`ifdef NTT_SCHED_PINGPONG_EN
  assign w_wb_in.bank = ~r_layer[0];
`endif

  ntt_wb_delay #(.D_NTT(D_NTT), .D_INTT(D_INTT)) u_wb_delay (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inv (r_inv),
    .i_d   (w_wb_in),
    .o_q   (w_wb_out)
  );

  assign bus.o_busy    = r_busy;
  assign bus.o_done    = r_done;
  assign bus.o_rd_en   = r_rd_en;
  assign bus.o_tw_addr = r_tw;
  assign bus.o_bf_mode = r_mode;
  assign bus.o_wr_en   = w_wb_out.vld;
`ifdef NTT_SCHED_PINGPONG_EN
  assign bus.o_rd_addr_a = {r_layer[0], r_rd_a};
  assign bus.o_rd_addr_b = {r_layer[0], r_rd_b};
  assign bus.o_wr_addr_a = {w_wb_out.bank, w_wb_out.a};
  assign bus.o_wr_addr_b = {w_wb_out.bank, w_wb_out.b};
`else
  assign bus.o_rd_addr_a = r_rd_a;
  assign bus.o_rd_addr_b = r_rd_b;
  assign bus.o_wr_addr_a = w_wb_out.a;
  assign bus.o_wr_addr_b = w_wb_out.b;
`endif
endmodule

// File: tb/tb_ntt_bf_sched.sv
// Cycle-level check of ntt_bf_sched against a Kyber-loop reference schedule.
module tb_ntt_bf_sched;
  import ntt_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ntt_bf_sched_if bus();
  ntt_bf_sched dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  int m_a  [2][7][128];
  int m_b  [2][7][128];
  int m_tw [2][7][128];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the Kyber ntt()/invntt() loop nests, recorded in issue order.
  task automatic build_model();
    int idx, len, k;
    k = 1;
    for (int l = 0; l < 7; l++) begin
      len = 128 >> l; idx = 0;
      for (int st = 0; st < 256; st += 2*len) begin
        for (int j = st; j < st + len; j++) begin
          m_a[0][l][idx] = j; m_b[0][l][idx] = j + len; m_tw[0][l][idx] = k; idx++;
        end
        k++;
      end
    end
    k = 127;
    for (int l = 0; l < 7; l++) begin
      len = 2 << l; idx = 0;
      for (int st = 0; st < 256; st += 2*len) begin
        for (int j = st; j < st + len; j++) begin
          m_a[1][l][idx] = j; m_b[1][l][idx] = j + len; m_tw[1][l][idx] = k; idx++;
        end
        k--;
      end
    end
  endtask

  function automatic int rd_bank(input int l);
`ifdef NTT_SCHED_PINGPONG_EN
    return (l & 1) << 8;
`else
    return 0;
`endif
  endfunction

  function automatic int wr_bank(input int l);
`ifdef NTT_SCHED_PINGPONG_EN
    return ((l & 1) ^ 1) << 8;
`else
    return 0;
`endif
  endfunction

  // Which butterfly (if any) is read in cycle t after a start accepted in cycle 0.
  task automatic rd_slot(input int t, input int D, input int done_t,
                         output bit v, output int l, output int c);
    int u;
    v = 1'b0; l = 0; c = 0;
    if (t >= 1 && t < done_t) begin
      u = t - 1;
      l = u / (128 + D);
      c = u % (128 + D);
      v = (c < 128);
    end
  endtask

  task automatic check_cycle(input int t, input bit inv, input int D, input int done_t);
    bit v; int l, c;
    rd_slot(t, D, done_t, v, l, c);
    chk("rd_en", 32'(bus.o_rd_en), 32'(v));
    if (v) begin
      chk("rd_addr_a", 32'(bus.o_rd_addr_a), 32'(m_a[inv][l][c] + rd_bank(l)));
      chk("rd_addr_b", 32'(bus.o_rd_addr_b), 32'(m_b[inv][l][c] + rd_bank(l)));
      chk("tw_addr",   32'(bus.o_tw_addr),   32'(m_tw[inv][l][c]));
    end
    rd_slot(t - D, D, done_t, v, l, c);
    chk("wr_en", 32'(bus.o_wr_en), 32'(v));
    if (v) begin
      chk("wr_addr_a", 32'(bus.o_wr_addr_a), 32'(m_a[inv][l][c] + wr_bank(l)));
      chk("wr_addr_b", 32'(bus.o_wr_addr_b), 32'(m_b[inv][l][c] + wr_bank(l)));
    end
    chk("done", 32'(bus.o_done), 32'(t == done_t));
    if (t < done_t) chk("busy", 32'(bus.o_busy), 32'd1);
    if (t > done_t) chk("busy_idle", 32'(bus.o_busy), 32'd0);
    chk("bf_mode", 32'(bus.o_bf_mode), (t <= done_t) ? 32'(inv) : 32'd3);
  endtask

  // Called at a negedge with the DUT idle; start is accepted in "cycle 0".
  task automatic run_xform(input bit inv, input int poke_at, input int abort_at);
    int D, done_t, n_wr;
    D = 1 + (inv ? 6 : 5);
    done_t = 1 + 7 * (128 + D);
    n_wr = 0;
    bus.i_inv = inv; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0; bus.i_inv = 1'($urandom);
    for (int t = 1; t <= done_t + 1; t++) begin
      check_cycle(t, inv, D, done_t);
      if (bus.o_wr_en === 1'b1) n_wr++;
      if (t == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy",  32'(bus.o_busy),    32'd0);
        chk("rst_wr_en", 32'(bus.o_wr_en),   32'd0);
        chk("rst_rd_en", 32'(bus.o_rd_en),   32'd0);
        chk("rst_mode",  32'(bus.o_bf_mode), 32'd3);
        rst = 1'b0;
        return;
      end
      bus.i_start = (t == poke_at);
      if (t == poke_at) bus.i_inv = 1'($urandom);
      @(negedge clk);
    end
    bus.i_start = 1'b0;
    chk("wr_count", 32'(n_wr), 32'd896);
  endtask

  initial begin
    bit rinv;
    build_model();
    bus.i_start = 1'b0; bus.i_inv = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy",  32'(bus.o_busy),      32'd0);
    chk("reset_done",  32'(bus.o_done),      32'd0);
    chk("reset_rd_en", 32'(bus.o_rd_en),     32'd0);
    chk("reset_wr_en", 32'(bus.o_wr_en),     32'd0);
    chk("reset_rd_a",  32'(bus.o_rd_addr_a), 32'd0);
    chk("reset_rd_b",  32'(bus.o_rd_addr_b), 32'd0);
    chk("reset_wr_a",  32'(bus.o_wr_addr_a), 32'd0);
    chk("reset_tw",    32'(bus.o_tw_addr),   32'd0);
    chk("reset_mode",  32'(bus.o_bf_mode),   32'd3);
    rst = 1'b0;
    @(negedge clk);

    run_xform(1'b0, 300, 0);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    run_xform(1'b1, 0, 0);
    run_xform(1'b0, 0, 200);
    run_xform(1'b0, 0, 0);

    rst = 1'b1; bus.i_start = 1'b1; bus.i_inv = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.i_start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", 32'(bus.o_busy),    32'd0);
    chk("rst_start_mode", 32'(bus.o_bf_mode), 32'd3);

    rinv = 1'($urandom);
    run_xform(rinv, $urandom_range(1, 900), 0);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    run_xform(~rinv, 0, $urandom_range(1, 900));
    run_xform(~rinv, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
